fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined 16-bit CPU. It owns the program counter, drives the instruction memory read port, and registers each fetched word into the IF/ID pipeline register for the decode stage and register-file read. It also applies stall and redirect requests from later stages and detects the HLT opcode so fetch stops cleanly.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HLT_OP, 4'hF, opcode (instr[15:12]) that halts fetch
- clk  in  1  global clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- redirect  in  1  taken branch/jump resolved downstream; load redirect_pc
- redirect_pc  in  16  target PC for redirect
- im_addr  out  16  instruction memory address (= pc)
- im_rd_en  out  1  instruction memory read enable
- im_instr  in  16  instruction word for im_addr, valid same cycle (combinational IM read)
- pc  out  16  current program counter
- if_id_instr  out  16  registered instruction to decode
- if_id_pc_plus1  out  16  registered PC+1 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_halted  out  1  HLT has been fetched; fetch frozen

## Operation
- States: RUN, HALTED (1 bit). Reset -> RUN.
- Word-addressed PC; sequential next PC = pc + 1, 16-bit modulo (16'hFFFF -> 16'h0000).
- im_addr = pc; im_rd_en = (state == RUN) && !stall.
- Per-edge priority: rst > redirect > stall > normal.
- rst: pc <= RESET_PC; if_id_valid <= 0; if_id_instr <= 0; if_id_pc_plus1 <= 0; state <= RUN.
- redirect (any state, regardless of stall): pc <= redirect_pc; if_id_valid <= 0 (squash the wrong-path word); state <= RUN. Redirect out of HALTED is required: an older branch may squash a speculatively fetched HLT.
- stall (no redirect): pc, IF/ID registers and state all hold.
- normal, RUN: if_id_instr <= im_instr; if_id_pc_plus1 <= pc + 1; if_id_valid <= 1.
  - If im_instr[15:12] != HLT_OP: pc <= pc + 1.
  - If im_instr[15:12] == HLT_OP: HLT still enters IF/ID (valid = 1) so it retires and raises the register-file hlt; pc holds; state <= HALTED.
- normal, HALTED: pc holds; if_id_valid <= 0 (bubbles); if_id_instr <= 0.
- fetch_halted = (state == HALTED).
- When if_id_valid = 0, if_id_instr is 16'h0000; downstream qualifies on if_id_valid only.

## Timing
- Fetch latency 1 cycle: word at pc appears on if_id_instr after the next rising edge.
- After rst deasserts, first edge captures IM[RESET_PC] (if_id_valid = 1, pc = RESET_PC+1).
- Redirect: target fetched in the cycle after the redirect edge; it reaches IF/ID one edge later (one bubble).
- HLT: fetch_halted rises the edge HLT enters IF/ID; pc stays at the HLT address.
- Stall has no effect on outputs beyond holding; no bubble inserted by this block.
- All outputs registered except im_addr, im_rd_en (decoded from registers, glitch-free per cycle).

## Test plan
- Reset then free run with IM[0..3] = 16'h1123, 16'h2234, 16'h3345, 16'h4456 -> if_id_instr follows in order on edges 1-4; if_id_pc_plus1 = 1,2,3,4; pc = 4.
- Assert stall for 2 cycles at pc = 2 -> pc stays 2, if_id_instr/valid unchanged, im_rd_en = 0; release -> fetch resumes at 2 with no lost/duplicated word.
- redirect with redirect_pc = 16'h0040 while stall = 1 -> next edge pc = 16'h0040, if_id_valid = 0; following edge IF/ID = IM[16'h0040].
- IM[5] = 16'hF000 -> HLT enters IF/ID with valid = 1, fetch_halted = 1, pc stays 5, subsequent edges if_id_valid = 0; then redirect to 16'h0010 -> state RUN, fetch_halted = 0, IM[16'h0010] fetched.
- pc preloaded to 16'hFFFF via redirect, normal fetch -> pc wraps to 16'h0000, if_id_pc_plus1 = 16'h0000.
- rst asserted mid-run with redirect and stall also high -> pc = RESET_PC, if_id_valid = 0, fetch_halted = 0 after that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory and fills the
// IF/ID register, honouring redirect/stall requests and freezing after an HLT fetch.
module fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  HLT_OP   = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] im_addr,
   output logic        im_rd_en,
   input  logic [15:0] im_instr,
   output logic [15:0] pc,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus1,
   output logic        if_id_valid,
   output logic        fetch_halted
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_plus1_q, pc_plus1_d;
   logic        valid_q, valid_d;
   logic [15:0] pc_inc;

   // 16-bit modulo increment: 16'hFFFF wraps to 16'h0000.
   assign pc_inc = pc_q + 16'd1;

   // Redirect beats stall; a bubble always carries an all-zero instruction word.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_plus1_d = pc_plus1_q;
      valid_d    = valid_q;
      if (redirect) begin
         pc_d    = redirect_pc;
         valid_d = 1'b0;
         instr_d = 16'h0000;
         state_d = RUN;
      end else if (!stall) begin
         case (state_q)
            RUN: begin
               instr_d    = im_instr;
               pc_plus1_d = pc_inc;
               valid_d    = 1'b1;
               if (im_instr[15:12] == HLT_OP) begin
                  state_d = HALTED;
               end else begin
                  pc_d = pc_inc;
               end
            end
            HALTED: begin
               valid_d = 1'b0;
               instr_d = 16'h0000;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         instr_q    <= 16'h0000;
         pc_plus1_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_plus1_q <= pc_plus1_d;
         valid_q    <= valid_d;
      end
   end

   assign im_addr        = pc_q;
   assign im_rd_en       = (state_q == RUN) && !stall;
   assign pc             = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus1 = pc_plus1_q;
   assign if_id_valid    = valid_q;
   assign fetch_halted   = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a program-memory model plus a per-cycle reference of the
// fetch rules, with literal expectations at the interesting points of each scenario.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall, redirect;
   logic [15:0] redirect_pc;
   logic [15:0] im_addr, im_instr, pc, if_id_instr, if_id_pc_plus1;
   logic        im_rd_en, if_id_valid, fetch_halted;

   logic [15:0] imem [0:65535];

   int n_checks = 0;
   int n_fail   = 0;

   // reference state, advanced on every rising edge
   logic [15:0] m_pc, m_instr, m_pcp1;
   logic        m_valid, m_halt;
   logic        m_live = 1'b0;

   fetch_stage #(.RESET_PC(16'h0000), .HLT_OP(4'hF)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .im_addr(im_addr), .im_rd_en(im_rd_en),
      .im_instr(im_instr), .pc(pc), .if_id_instr(if_id_instr),
      .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid),
      .fetch_halted(fetch_halted)
   );

   always #5 clk = ~clk;

   assign im_instr = imem[im_addr];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: priority rst > redirect > stall > fetch, written from the operation rules.
   always @(posedge clk) begin
      logic [15:0] w;
      if (rst) begin
         m_pc = 16'h0000; m_valid = 1'b0; m_instr = 16'h0000; m_pcp1 = 16'h0000;
         m_halt = 1'b0; m_live = 1'b1;
      end else if (redirect) begin
         m_pc = redirect_pc; m_valid = 1'b0; m_instr = 16'h0000; m_halt = 1'b0;
      end else if (!stall) begin
         if (!m_halt) begin
            w       = imem[m_pc];
            m_instr = w;
            m_pcp1  = m_pc + 16'd1;
            m_valid = 1'b1;
            if (w[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd1;
         end else begin
            m_valid = 1'b0;
            m_instr = 16'h0000;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("pc", pc, m_pc);
         chk("im_addr", im_addr, m_pc);
         chk("im_rd_en", {15'd0, im_rd_en}, {15'd0, (!m_halt && !stall)});
         chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, m_valid});
         chk("if_id_instr", if_id_instr, m_instr);
         chk("if_id_pc_plus1", if_id_pc_plus1, m_pcp1);
         chk("fetch_halted", {15'd0, fetch_halted}, {15'd0, m_halt});
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_in(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         logic [15:0] a;
         a = i[15:0];
         imem[i] = {4'h1, a[11:0]};
      end
      imem[0] = 16'h1123; imem[1] = 16'h2234; imem[2] = 16'h3345; imem[3] = 16'h4456;
      imem[4] = 16'h5567; imem[5] = 16'hF000;
      imem[16'h0010] = 16'h7ABC;
      imem[16'h0040] = 16'h6040;

      set_in(1'b1, 1'b0, 1'b0, 16'h0000);
      step(2);
      chk("lit reset pc", pc, 16'h0000);
      chk("lit reset valid", {15'd0, if_id_valid}, 16'h0000);
      chk("lit reset instr", if_id_instr, 16'h0000);
      chk("lit reset halted", {15'd0, fetch_halted}, 16'h0000);

      // free run, stall 2 cycles at pc = 2, resume
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1);
      chk("lit first instr", if_id_instr, 16'h1123);
      chk("lit first pcp1", if_id_pc_plus1, 16'h0001);
      step(1);
      chk("lit pc at 2", pc, 16'h0002);
      stall = 1'b1;
      #1;
      chk("lit rd_en stalled", {15'd0, im_rd_en}, 16'h0000);
      step(2);
      chk("lit stall pc", pc, 16'h0002);
      chk("lit stall instr", if_id_instr, 16'h2234);
      stall = 1'b0;
      step(1);
      chk("lit resume instr", if_id_instr, 16'h3345);
      step(1);
      chk("lit run instr4", if_id_instr, 16'h4456);
      chk("lit run pcp1 4", if_id_pc_plus1, 16'h0004);
      chk("lit run pc 4", pc, 16'h0004);

      // HLT at 5
      step(2);
      chk("lit hlt instr", if_id_instr, 16'hF000);
      chk("lit hlt valid", {15'd0, if_id_valid}, 16'h0001);
      chk("lit hlt halted", {15'd0, fetch_halted}, 16'h0001);
      chk("lit hlt pc", pc, 16'h0005);
      step(2);
      chk("lit halted bubble", {15'd0, if_id_valid}, 16'h0000);
      chk("lit halted pc", pc, 16'h0005);

      // redirect out of HALTED
      set_in(1'b0, 1'b0, 1'b1, 16'h0010);
      step(1);
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("lit unhalt", {15'd0, fetch_halted}, 16'h0000);
      chk("lit redir bubble", {15'd0, if_id_valid}, 16'h0000);
      step(1);
      chk("lit redir target", if_id_instr, 16'h7ABC);

      // redirect wins over stall
      set_in(1'b0, 1'b1, 1'b1, 16'h0040);
      step(1);
      chk("lit redir+stall pc", pc, 16'h0040);
      chk("lit redir+stall valid", {15'd0, if_id_valid}, 16'h0000);
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1);
      chk("lit 0x40 instr", if_id_instr, 16'h6040);

      // wrap at 16'hFFFF
      set_in(1'b0, 1'b0, 1'b1, 16'hFFFF);
      step(1);
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1);
      chk("lit wrap pc", pc, 16'h0000);
      chk("lit wrap pcp1", if_id_pc_plus1, 16'h0000);
      chk("lit wrap instr", if_id_instr, 16'h1FFF);

      // mixed stall pattern checked by the reference only
      for (int i = 0; i < 24; i++) begin
         stall = (i % 3 == 1) || (i % 7 == 0);
         step(1);
      end
      stall = 1'b0;

      // halt again, then reset with redirect and stall also high
      set_in(1'b0, 1'b0, 1'b1, 16'h0005);
      step(1);
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1);
      chk("lit rehalt", {15'd0, fetch_halted}, 16'h0001);
      set_in(1'b1, 1'b1, 1'b1, 16'h0123);
      step(1);
      chk("lit rst pc", pc, 16'h0000);
      chk("lit rst valid", {15'd0, if_id_valid}, 16'h0000);
      chk("lit rst halted", {15'd0, fetch_halted}, 16'h0000);
      set_in(1'b0, 1'b0, 1'b0, 16'h0000);
      step(2);
      chk("lit post-rst instr", if_id_instr, 16'h2234);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
